// File: rtl/csi2tx_n_lane_ldl.sv
// CSI-2 TX lane distribution layer: stripes bytes of 64-bit FIFO words
// round-robin across 1/2/4/8 PPI HS lanes and sequences the HS exit.
module csi2tx_n_lane_ldl #(
  parameter int MAX_LANES = 8,
  parameter int PKT_LEN_W = 16,
  parameter int HS_EXIT_W = 8
) (
  input  logic                   txbyteclkhs,
  input  logic                   txbyteclkhs_rst_n,
  input  logic                   tinit_start,
  input  logic                   forcetxstopmode,
  input  logic [1:0]             lane_mode,
  input  logic                   enable_hs_transmission,
  input  logic                   csi_byte_fifo_empty,
  input  logic [63:0]            fifo_rd_data,
  input  logic [PKT_LEN_W-1:0]   pkt_len,
  input  logic [MAX_LANES-1:0]   txreadyhs,
  input  logic                   stop_state_dl,
  output logic                   fifo_rd_en,
  output logic                   header_info,
  output logic                   wr_size_decr_pulse,
  output logic [MAX_LANES-1:0]   txrequesths,
  output logic [8*MAX_LANES-1:0] txdatahs,
  output logic                   tx_done,
  output logic                   hs_exit_active
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDHDR = 3'd1;
  localparam logic [2:0] S_DLY = 3'd2;
  localparam logic [2:0] S_REQ = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_EXIT = 3'd5;

  localparam logic [HS_EXIT_W-1:0] HS_EXIT_CYCLES = HS_EXIT_W'(8);
  localparam int LW = PKT_LEN_W + 1;
  localparam logic [PKT_LEN_W-1:0] MIN_LEN = PKT_LEN_W'(4);

  logic [2:0]           state_q, state_d;
  logic [3:0]           n_q, n_d, n_sel;
  logic [2:0]           off_q, off_d, idx;
  logic [PKT_LEN_W-1:0] sent_q, sent_d;
  logic [PKT_LEN_W-1:0] len_q, len_d;
  logic [HS_EXIT_W-1:0] exit_q, exit_d;
  logic [MAX_LANES-1:0] req_q, req_d;
  logic                 abort, acc, last, entry;
  logic [3:0]           off_sum;
  logic [LW-1:0]        sent_sum;
  logic                 unused_ready;

  assign unused_ready = ^txreadyhs;

  always_comb begin
    abort = forcetxstopmode | ~tinit_start;
    n_sel = 4'd1 << lane_mode;
    if (n_sel > 4'(MAX_LANES)) n_sel = 4'(MAX_LANES);
    // lane 0 is always requested, so a low req_q[0] marks REQ_HS entry
    entry = (state_q == S_REQ) & ~req_q[0];
    acc = (state_q == S_REQ) & req_q[0] & txreadyhs[0];
    off_sum = {1'b0, off_q} + n_q;
    sent_sum = {1'b0, sent_q} + LW'(n_q);
    last = sent_sum >= {1'b0, len_q};
  end

  always_comb begin
    state_d = state_q;
    n_d = n_q;
    off_d = off_q;
    sent_d = sent_q;
    len_d = len_q;
    exit_d = exit_q;
    req_d = req_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_hs_transmission & ~csi_byte_fifo_empty) begin
          state_d = S_RDHDR;
          n_d = n_sel;
        end
      end
      S_RDHDR: state_d = S_DLY;
      S_DLY: begin
        len_d = (pkt_len < MIN_LEN) ? MIN_LEN : pkt_len;
        off_d = '0;
        sent_d = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (entry) begin
          for (int k = 0; k < MAX_LANES; k++)
            req_d[k] = (4'(k) < n_q) && (LW'(k) < {1'b0, len_q});
        end else if (acc) begin
          off_d = off_sum[2:0];
          sent_d = sent_sum[PKT_LEN_W] ? '1 : sent_sum[PKT_LEN_W-1:0];
          for (int k = 0; k < MAX_LANES; k++)
            req_d[k] = req_q[k] && ((sent_sum + LW'(k)) < {1'b0, len_q});
          if (last) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_state_dl) begin
          state_d = S_EXIT;
          exit_d = HS_EXIT_CYCLES;
        end
      end
      S_EXIT: begin
        if (exit_q == '0) state_d = S_IDLE;
        else exit_d = exit_q - HS_EXIT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      off_d = '0;
      sent_d = '0;
      len_d = '0;
      exit_d = '0;
      req_d = '0;
    end
  end

  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      state_q <= S_IDLE;
      n_q <= '0;
      off_q <= '0;
      sent_q <= '0;
      len_q <= '0;
      exit_q <= '0;
      req_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      off_q <= off_d;
      sent_q <= sent_d;
      len_q <= len_d;
      exit_q <= exit_d;
      req_q <= req_d;
    end
  end

  always_comb begin
    txdatahs = '0;
    idx = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      idx = off_q + 3'(k);
      if ((state_q == S_REQ) && (4'(k) < n_q) &&
          ((LW'(sent_q) + LW'(k)) < {1'b0, len_q}))
        txdatahs[8*k +: 8] = fifo_rd_data[{idx, 3'b000} +: 8];
    end
  end

  // refill only when this beat drains the word and bytes remain
  assign fifo_rd_en = ~abort &
                      ((state_q == S_RDHDR) | (acc & off_sum[3] & ~last));
  assign header_info = state_q == S_DLY;
  assign wr_size_decr_pulse = entry & ~abort;
  assign txrequesths = req_q & {MAX_LANES{tinit_start}};
  assign tx_done = state_q == S_WAIT;
  assign hs_exit_active = state_q == S_EXIT;

endmodule

// File: doc/csi2tx_n_lane_ldl.md
Name: csi2tx_n_lane_ldl

Overview:
Parametrised CSI-2 TX lane distribution layer for 1, 2, 4 or 8 D-PHY data lanes, selected at run time. It reads 64-bit words from the CSI byte FIFO and stripes packet bytes round-robin across the active lanes (byte b goes to lane b mod N). It drives the per-lane PPI HS request/data signals and ends each lane's request individually at that lane's last byte. An internal HS-exit timer sequences the return to idle. It sits between the packet/byte FIFO and the D-PHY PPI.

Parameters:
MAX_LANES, 8, number of physical lanes; legal values 1, 2, 4, 8
PKT_LEN_W, 16, width of the packet byte-length input
HS_EXIT_W, 8, width of the HS-exit cycle count

Ports:
txbyteclkhs  in  1  HS byte clock
txbyteclkhs_rst_n  in  1  reset, asynchronous, active-low
tinit_start  in  1  PHY init done; while low, requests are forced low and the block stays in IDLE
forcetxstopmode  in  1  synchronous abort: returns the block to IDLE
lane_mode  in  2  active lanes: 0=1, 1=2, 2=4, 3=8; clamped to MAX_LANES
enable_hs_transmission  in  1  permits a packet to start
csi_byte_fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  64  FIFO read data, valid the cycle after fifo_rd_en
pkt_len  in  PKT_LEN_W  total packet bytes (header+payload+footer), valid while header_info=1
txreadyhs  in  MAX_LANES  PPI ready per lane; only lane 0 is used for pacing
stop_state_dl  in  1  all active lanes are in stop state
fifo_rd_en  out  1  FIFO read strobe
header_info  out  1  header word present on fifo_rd_data
wr_size_decr_pulse  out  1  one-cycle pulse on REQ_HS entry
txrequesths  out  MAX_LANES  per-lane HS request
txdatahs  out  8*MAX_LANES  lane k byte at [8k+7:8k]
tx_done  out  1  high in WAIT_STOP
hs_exit_active  out  1  high in HS_EXIT

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0.
- Internal quantities: N = active lane count; off = 3-bit byte offset within the current FIFO word; sent = PKT_LEN_W-bit count of bytes already sent; L = latched packet length; exit_cnt = HS-exit down-counter.
- IDLE -> RD_HDR when tinit_start, enable_hs_transmission and !csi_byte_fifo_empty are all high. lane_mode is sampled into N on this transition and ignored for the rest of the packet.
- RD_HDR: fifo_rd_en=1 for this one cycle. Next state DLY.
- DLY: header_info=1. L <= max(pkt_len, 4); off and sent cleared. Next state REQ_HS.
- REQ_HS entry cycle: wr_size_decr_pulse=1. txrequesths[k] set on the next clock for every k<N with k<L.
- Beat acceptance: a beat is accepted when txrequesths[0] & txreadyhs[0]. On acceptance: off <= off+N (mod 8); sent <= sent+N. If txreadyhs[0] is low, the beat is held and off, sent and txdatahs do not change.
- txdatahs lane k = fifo_rd_data[8(off+k)+7 : 8(off+k)] when k<N and sent+k<L; otherwise 0x00.
- fifo_rd_en is combinational in REQ_HS: asserted on an accepted beat where off+N wraps to 0 and sent+N<L. New data is used by the next beat. No read is issued past the end of the packet.
- Per-lane request end: txrequesths[k] clears the cycle after the last accepted beat in which lane k was valid.
- REQ_HS -> WAIT_STOP on acceptance of the beat with sent+N>=L. Lane 0 is always valid in the final beat.
- WAIT_STOP: tx_done=1. -> HS_EXIT when stop_state_dl=1; exit_cnt is loaded with HS_EXIT_CYCLES (localparam, default 8'd8).
- HS_EXIT: hs_exit_active=1; exit_cnt decrements each cycle. -> IDLE on the cycle exit_cnt==0. A load value of 0 spends exactly 1 cycle in HS_EXIT.
- forcetxstopmode=1 in any state: next cycle state=IDLE, txrequesths=0, counters cleared, fifo_rd_en=0 in that cycle. Takes priority over every transition.
- tinit_start low in mid-packet: requests forced low and the block aborts to IDLE, same as forcetxstopmode.
- Lanes k>=N: request and data held at 0 at all times.
- sent arithmetic saturates at all-ones; L up to 2^PKT_LEN_W-1 is supported.

Test Plan:
1-lane, L=4, word bytes 0x03020100 -> lane0 sends 00,01,02,03 over 4 beats; fifo_rd_en asserted only in RD_HDR; request drops after beat 3; tx_done follows.
4-lane, L=10 -> beat0 lanes 0-3 = bytes 0-3; beat1 = bytes 4-7 with fifo_rd_en=1; beat2 lanes 0,1 = bytes 8,9. txrequesths[3:2] clear after beat1; [1:0] clear after beat2.
8-lane, L=24, txreadyhs held high -> exactly 3 FIFO reads (RD_HDR plus beats 0 and 1); 3 beats; all requests drop together.
2-lane, L=8, txreadyhs[0] low for 3 cycles at beat1 -> txdatahs stable throughout the stall; no extra fifo_rd_en; packet completes in 4 accepted beats.
forcetxstopmode pulsed mid-packet in 8-lane mode -> next cycle txrequesths=0, state IDLE; the next packet starts cleanly with off=0.
stop_state_dl asserted with HS_EXIT_CYCLES=3 -> hs_exit_active high for 4 cycles, then IDLE; a new packet is accepted only after that.
